obi_data_responder: RTL and testbench



---
 rtl/obi_data_responder_pkg.sv | 12 +
 rtl/obi_data_responder_if.sv | 14 +
 rtl/obi_data_responder_delay.sv | 24 ++
 rtl/obi_data_responder.sv | 63 ++++++
 tb/tb_obi_data_responder.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/obi_data_responder_pkg.sv
// obi_resp_pkg: shared response entry type and sizing helpers for the data responder
package obi_resp_pkg;
  localparam int WAIT_W = 3;
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } resp_entry_t;
  function automatic int idx_w(int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/obi_data_responder_if.sv
// obi_data_responder_if: data-side load/store bus between core (master) and memory (slave)
interface obi_data_responder_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  modport master(output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave(input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_data_responder_delay.sv
// resp_delay_line: fixed-latency shift register carrying responses from grant to rvalid
module resp_delay_line
  import obi_resp_pkg::*;
#(
  parameter int RESP_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  resp_entry_t push,
  output resp_entry_t head,
  output logic        retire
);
  resp_entry_t stage_q [RESP_LATENCY];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RESP_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= push;
      for (int i = 1; i < RESP_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end
  assign head   = stage_q[RESP_LATENCY-1];
  assign retire = head.valid;
endmodule

// File: rtl/obi_data_responder.sv
// obi_data_responder: word-addressed memory responder with grant stall and fixed response latency
module obi_data_responder
  import obi_resp_pkg::*;
#(
  parameter int          DEPTH           = 16,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          GNT_DELAY       = 0,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] INIT_SEED       = 32'h0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  obi_data_responder_if.slave  bus,
  output logic [31:0]          access_cnt_o,
  output logic [31:0]          err_cnt_o
);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [31:0]       mem_q [DEPTH];
  logic [WAIT_W-1:0] wait_q;
  logic [OUT_W-1:0]  out_q;
  logic [29:0]       widx;
  logic [IDX_W-1:0]  idx;
  logic              err_hit, gnt, retire;
  resp_entry_t       push, head;
  // addresses below BASE_ADDR wrap to a huge word index and decode as errors
  assign widx    = 30'((bus.addr - BASE_ADDR) >> 2);
  assign err_hit = widx >= 30'(DEPTH);
  assign idx     = widx[IDX_W-1:0];
  assign gnt     = !rst_i && bus.req && wait_q == WAIT_W'(GNT_DELAY)
                   && !(out_q == OUT_W'(MAX_OUTSTANDING) && !retire);
  assign push    = '{valid: gnt, err: gnt && err_hit,
                     rdata: (gnt && !bus.we && !err_hit) ? mem_q[idx] : '0};
  resp_delay_line #(.RESP_LATENCY(RESP_LATENCY)) u_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .head  (head),
    .retire(retire)
  );
  assign bus.gnt    = gnt;
  assign bus.rvalid = head.valid && !rst_i;
  assign bus.err    = head.err && !rst_i;
  assign bus.rdata  = rst_i ? '0 : head.rdata;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_SEED + 32'(i);
      wait_q       <= '0;
      out_q        <= '0;
      access_cnt_o <= '0;
      err_cnt_o    <= '0;
    end else begin
      if (gnt && bus.we && !err_hit)
        for (int k = 0; k < 4; k++) if (bus.be[k]) mem_q[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
      // stall counter parks at GNT_DELAY so an outstanding-limit stall grants as soon as room frees
      wait_q       <= (gnt || !bus.req) ? '0 : wait_q + WAIT_W'(wait_q != WAIT_W'(GNT_DELAY));
      out_q        <= out_q + OUT_W'(gnt) - OUT_W'(retire);
      access_cnt_o <= access_cnt_o + 32'(gnt);
      err_cnt_o    <= err_cnt_o + 32'(retire && head.err);
    end
  end
endmodule

// File: tb/tb_obi_data_responder.sv
// tb_obi_data_responder: directed and scoreboard checks over four responder configurations
module tb_obi_data_responder;
  import obi_resp_pkg::*;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  obi_data_responder_if a_if(), b_if(), c_if(), d_if();
  logic [31:0] a_acc, a_errc, b_acc, b_errc, c_acc, c_errc, d_acc, d_errc;
  obi_data_responder #(.INIT_SEED(32'h100)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(a_if), .access_cnt_o(a_acc), .err_cnt_o(a_errc));
  obi_data_responder #(.GNT_DELAY(3), .BASE_ADDR(32'h1000)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(b_if), .access_cnt_o(b_acc), .err_cnt_o(b_errc));
  obi_data_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_c (
    .clk_i(clk), .rst_i(rst), .bus(c_if), .access_cnt_o(c_acc), .err_cnt_o(c_errc));
  obi_data_responder #(.RESP_LATENCY(2), .MAX_OUTSTANDING(2)) u_d (
    .clk_i(clk), .rst_i(rst), .bus(d_if), .access_cnt_o(d_acc), .err_cnt_o(d_errc));

  typedef struct {logic err; logic [31:0] rdata;} exp_t;
  exp_t exp_q[$];
  logic [31:0] model [16];
  exp_t e;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata);
    a_if.req = 1; a_if.we = we; a_if.be = be; a_if.addr = addr; a_if.wdata = wdata;
  endtask

  // scoreboard for instance A: expectations pushed at grant from the model, popped at rvalid
  always @(negedge clk) begin
    if (!rst) begin
      if (a_if.rvalid) begin
        if (exp_q.size() == 0) chk("a_sb_extra", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("a_sb_err", 32'(a_if.err), 32'(e.err));
          chk("a_sb_rdata", a_if.rdata, e.rdata);
        end
      end
      if (a_if.gnt) begin
        e.err = a_if.addr[31:2] >= 30'd16;
        e.rdata = (!a_if.we && !e.err) ? model[a_if.addr[5:2]] : 32'h0;
        exp_q.push_back(e);
        if (a_if.we && !e.err)
          for (int k = 0; k < 4; k++)
            if (a_if.be[k]) model[a_if.addr[5:2]][8*k +: 8] = a_if.wdata[8*k +: 8];
      end
    end
  end

  initial begin
    logic [8:0] gbits, rbits;
    int nload, rv_seen;
    for (int i = 0; i < 16; i++) model[i] = 32'h100 + 32'(i);
    a_if.req = 0; a_if.we = 0; a_if.be = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.req = 0; b_if.we = 0; b_if.be = 0; b_if.addr = 0; b_if.wdata = 0;
    c_if.req = 0; c_if.we = 0; c_if.be = 0; c_if.addr = 0; c_if.wdata = 0;
    d_if.req = 0; d_if.we = 0; d_if.be = 0; d_if.addr = 0; d_if.wdata = 0;
    tick();
    a_drive(0, 4'h0, 32'h0C, 32'h0);
    @(negedge clk);
    chk("rst_gnt", 32'(a_if.gnt), 0);
    chk("rst_rvalid", 32'(a_if.rvalid), 0);
    chk("rst_acc", a_acc, 0);
    chk("rst_errc", a_errc, 0);
    tick();
    rst = 0;
    @(negedge clk);
    chk("a_gnt_first", 32'(a_if.gnt), 1);
    tick();
    a_if.req = 0;
    @(negedge clk);
    chk("a_rvalid_lat1", 32'(a_if.rvalid), 1);
    chk("a_rdata_seed", a_if.rdata, 32'h103);
    chk("a_err_good", 32'(a_if.err), 0);
    chk("a_acc_1", a_acc, 1);
    tick();
    a_drive(1, 4'b0101, 32'h08, 32'hAABBCCDD);
    tick();
    a_drive(0, 4'h0, 32'h08, 32'h0);
    tick();
    a_if.req = 0;
    @(negedge clk);
    chk("a_raw", a_if.rdata, 32'h00BB01DD);
    tick();
    a_drive(0, 4'h0, 32'h40, 32'h0);
    tick();
    a_if.req = 0;
    @(negedge clk);
    chk("a_err_rvalid", 32'(a_if.rvalid), 1);
    chk("a_err_flag", 32'(a_if.err), 1);
    chk("a_err_rdata", a_if.rdata, 0);
    tick();
    chk("a_errc_1", a_errc, 1);
    a_drive(1, 4'hF, 32'h40, 32'hFFFFFFFF);
    tick();
    a_drive(0, 4'h0, 32'h00, 32'h0);
    tick();
    a_if.req = 0;
    @(negedge clk);
    chk("a_err_store_nowrite", a_if.rdata, 32'h100);
    tick();
    for (int i = 0; i < 40; i++) begin
      a_drive(1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom_range(0, 19)) * 4, $urandom);
      tick();
    end
    a_if.req = 0;
    repeat (3) tick();
    chk("a_sb_drain", 32'(exp_q.size()), 0);
    chk("a_acc_total", a_acc, 46);

    b_if.req = 1; b_if.addr = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_gnt_hold", 32'(b_if.gnt), 32'(i == 3));
      tick();
    end
    b_if.req = 0;
    @(negedge clk);
    chk("b_rvalid", 32'(b_if.rvalid), 1);
    chk("b_rdata", b_if.rdata, 0);
    tick();
    b_if.req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("b_gnt_pre_drop", 32'(b_if.gnt), 0);
      tick();
    end
    b_if.req = 0;
    tick();
    b_if.req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_gnt_after_drop", 32'(b_if.gnt), 32'(i == 3));
      tick();
    end
    b_if.req = 1; b_if.addr = 32'h0FFC;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_gnt_below", 32'(b_if.gnt), 32'(i == 3));
      tick();
    end
    b_if.req = 0;
    @(negedge clk);
    chk("b_below_err", 32'(b_if.err), 1);
    chk("b_below_rdata", b_if.rdata, 0);

    tick();
    nload = 0;
    c_if.req = 1; c_if.addr = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      gbits[i] = c_if.gnt;
      rbits[i] = c_if.rvalid;
      if (c_if.gnt) nload++;
      tick();
      c_if.addr = 32'(nload) * 4;
      if (nload == 4) c_if.req = 0;
    end
    chk("c_gnt_pattern", 32'(gbits), 32'h01B);
    chk("c_rvalid_pattern", 32'(rbits), 32'h0D8);
    chk("c_acc", c_acc, 4);

    d_if.req = 1; d_if.we = 1; d_if.be = 4'hF; d_if.addr = 32'h4; d_if.wdata = 32'hDEADBEEF;
    tick();
    d_if.we = 0; d_if.be = 0;
    @(negedge clk);
    chk("d_gnt_load", 32'(d_if.gnt), 1);
    tick();
    d_if.req = 0;
    rst = 1;
    @(negedge clk);
    chk("d_rst_rvalid", 32'(d_if.rvalid), 0);
    tick();
    rst = 0;
    rv_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (d_if.rvalid) rv_seen++;
      tick();
    end
    chk("d_dropped", 32'(rv_seen), 0);
    chk("d_acc_cleared", d_acc, 0);
    chk("d_errc_cleared", d_errc, 0);
    d_if.req = 1; d_if.addr = 32'h4;
    tick();
    d_if.req = 0;
    tick();
    @(negedge clk);
    chk("d_rvalid_lat2", 32'(d_if.rvalid), 1);
    chk("d_mem_reseeded", d_if.rdata, 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
